// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch bus: the fetch unit drives the address, and memory
// answers with the instruction at that address in the same cycle.
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  if_from_pc;
  logic [INSTR_W-1:0] if_instruction;

  modport master (output if_from_pc, input  if_instruction);
  modport slave  (input  if_from_pc, output if_instruction);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches from instruction memory and fills IF/ID.
// Handles stall, flush, branch redirect, and stops fetching after a halt instruction.
//
// state  | meaning
// BOOT   | first cycle after reset, PC and IF/ID hold
// RUN    | normal fetch; priority is branch > stall > normal capture
// HALTED | halt captured; PC frozen, IF/ID bubbles until a branch
module fetch_unit #(
  parameter int                  ADDR_W     = 16,
  parameter int                  INSTR_W    = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC   = '0,
  parameter int                  PC_STEP    = 2,
  parameter logic [INSTR_W-1:0]  NOP_INSTR  = '0,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = '1
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                branch_taken_i,
  input  logic [ADDR_W-1:0]   branch_target_i,
  output logic [INSTR_W-1:0]  ifid_instruction_o,
  output logic [ADDR_W-1:0]   ifid_pc_o,
  output logic [ADDR_W-1:0]   ifid_pc_plus2_o,
  output logic                ifid_valid_o,
  output logic                halted_o
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALTED} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]    ifid_pc_q, ifid_pc_d;
  logic [ADDR_W-1:0]    ifid_pc2_q, ifid_pc2_d;
  logic                 ifid_valid_q, ifid_valid_d;

  logic [ADDR_W-1:0]    pc_inc;
  logic [ADDR_W-1:0]    target_aligned;
  logic                 is_halt;

  assign pc_inc         = pc_q + ADDR_W'(PC_STEP);
  assign target_aligned = {branch_target_i[ADDR_W-1:1], 1'b0};
  assign is_halt        = (imem.if_instruction == HALT_INSTR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc2_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc2_q   <= ifid_pc2_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:   state_d = S_RUN;
      S_RUN:    if (!branch_taken_i && !stall_i && !flush_i && is_halt) state_d = S_HALTED;
      S_HALTED: if (branch_taken_i) state_d = S_RUN;
      default:  state_d = S_BOOT;
    endcase
  end

  // A bubble keeps ifid_pc/ifid_pc_plus2 so the stage still reports where it sits.
  always_comb begin
    pc_d         = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc2_d   = ifid_pc2_q;
    ifid_valid_d = ifid_valid_q;
    halted_o     = (state_q == S_HALTED);
    case (state_q)
      S_RUN: begin
        if (branch_taken_i) begin
          pc_d         = target_aligned;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (stall_i) begin
          if (flush_i) begin
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
        end else if (flush_i) begin
          pc_d         = pc_inc;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else begin
          pc_d         = is_halt ? pc_q : pc_inc;
          ifid_instr_d = imem.if_instruction;
          ifid_pc_d    = pc_q;
          ifid_pc2_d   = pc_inc;
          ifid_valid_d = 1'b1;
        end
      end
      S_HALTED: begin
        if (branch_taken_i) pc_d = target_aligned;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign imem.if_from_pc = pc_q;
  assign ifid_instruction_o = ifid_instr_q;
  assign ifid_pc_o          = ifid_pc_q;
  assign ifid_pc_plus2_o    = ifid_pc2_q;
  assign ifid_valid_o       = ifid_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stall/flush/branch traffic, all compared against a behavioural fetch model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, br = 1'b0;
  logic [15:0] tgt = '0;
  logic [15:0] ifid_instr, ifid_pc, ifid_pc2;
  logic        ifid_valid, halted;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:32767];

  fetch_unit_if #(.ADDR_W(16), .INSTR_W(16)) imem ();

  always #5 clk = ~clk;

  assign imem.if_instruction = mem[imem.if_from_pc[15:1]];

  fetch_unit dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem               (imem),
    .stall_i            (stall),
    .flush_i            (flush),
    .branch_taken_i     (br),
    .branch_target_i    (tgt),
    .ifid_instruction_o (ifid_instr),
    .ifid_pc_o          (ifid_pc),
    .ifid_pc_plus2_o    (ifid_pc2),
    .ifid_valid_o       (ifid_valid),
    .halted_o           (halted)
  );

  // Behavioural model of the fetch stage
  logic [15:0] m_pc, m_instr, m_ipc, m_ipc2;
  logic        m_valid, m_halted, m_boot;

  task automatic model_reset();
    m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000; m_ipc2 = 16'h0000;
    m_valid = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
  endtask

  task automatic model_bubble();
    m_instr = 16'h0000;
    m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic b, input logic [15:0] t, input logic s, input logic f);
    logic [15:0] fetched;
    fetched = mem[m_pc >> 1];
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halted) begin
      model_bubble();
      if (b) begin
        m_pc = t & 16'hFFFE;
        m_halted = 1'b0;
      end
    end else if (b) begin
      m_pc = t & 16'hFFFE;
      model_bubble();
    end else if (s) begin
      if (f) model_bubble();
    end else if (f) begin
      m_pc = m_pc + 16'd2;
      model_bubble();
    end else begin
      m_instr = fetched;
      m_ipc   = m_pc;
      m_ipc2  = m_pc + 16'd2;
      m_valid = 1'b1;
      if (fetched == 16'hFFFF) m_halted = 1'b1;
      else                     m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " pc"},     imem.if_from_pc, m_pc);
    chk({tag, " instr"},  ifid_instr, m_instr);
    chk({tag, " ifid_pc"}, ifid_pc, m_ipc);
    chk({tag, " pc2"},    ifid_pc2, m_ipc2);
    chk({tag, " valid"},  {15'd0, ifid_valid}, {15'd0, m_valid});
    chk({tag, " halted"}, {15'd0, halted}, {15'd0, m_halted});
  endtask

  // Inputs are applied at a negedge, the model advances at the posedge,
  // and outputs are compared at the following negedge.
  task automatic step(input string tag, input logic b, input logic [15:0] t,
                      input logic s, input logic f);
    br = b; tgt = t; stall = s; flush = f;
    @(posedge clk);
    model_edge(b, t, s, f);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem[i] = 16'($urandom_range(0, 16'hFFFE));
    end
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
    mem[16'h0010 >> 1] = 16'hFFFF;

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // BOOT ignores a branch request
    step("boot", 1'b1, 16'h1234, 1'b1, 1'b1);
    chk("boot valid", {15'd0, ifid_valid}, 16'd0);
    chk("boot pc", imem.if_from_pc, 16'h0000);

    step("fetch0", 1'b0, 16'h0, 1'b0, 1'b0);
    chk("fetch0 instr", ifid_instr, 16'h1111);
    chk("fetch0 pc2", ifid_pc2, 16'h0002);
    run("fetch", 2);
    chk("fetch4 instr", ifid_instr, 16'h3333);
    chk("fetch4 pc2", ifid_pc2, 16'h0006);

    step("stall", 1'b0, 16'h0, 1'b1, 1'b0);
    step("stall", 1'b0, 16'h0, 1'b1, 1'b0);
    chk("stall pc", imem.if_from_pc, 16'h0006);
    step("flush", 1'b0, 16'h0, 1'b0, 1'b1);
    chk("flush valid", {15'd0, ifid_valid}, 16'd0);
    chk("flush pc", imem.if_from_pc, 16'h0008);

    step("brstall", 1'b1, 16'h0041, 1'b1, 1'b0);
    chk("brstall pc", imem.if_from_pc, 16'h0040);
    step("br40", 1'b0, 16'h0, 1'b0, 1'b0);
    chk("br40 ifid_pc", ifid_pc, 16'h0040);

    step("brwrap", 1'b1, 16'hFFFE, 1'b0, 1'b0);
    step("wrap", 1'b0, 16'h0, 1'b0, 1'b0);
    chk("wrap pc", imem.if_from_pc, 16'h0000);
    chk("wrap pc2", ifid_pc2, 16'h0000);

    run("to_halt", 8);
    step("halt", 1'b0, 16'h0, 1'b0, 1'b0);
    chk("halt instr", ifid_instr, 16'hFFFF);
    chk("halt halted", {15'd0, halted}, 16'd1);
    for (int i = 0; i < 5; i++) step("halted", 1'b0, 16'h0, i[0], i[1]);
    chk("halted pc", imem.if_from_pc, 16'h0010);
    step("unhalt", 1'b1, 16'h0020, 1'b0, 1'b0);
    chk("unhalt halted", {15'd0, halted}, 16'd0);
    run("resume", 2);
    chk("resume pc", imem.if_from_pc, 16'h0024);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async");
    chk("async pc", imem.if_from_pc, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step("boot2", 1'b0, 16'h0, 1'b0, 1'b0);
    run("refetch", 2);

    // Random traffic with sparse halts
    for (int i = 0; i < 4096; i++) begin
      if ($urandom_range(0, 31) == 0) mem[i] = 16'hFFFF;
    end
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           ($urandom_range(0, 7) == 0),
           16'($urandom_range(0, 16'h1FFF)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 5) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Initiator side of the instruction-memory interface. Owns the program counter, drives the fetch address into instruction_memory, and captures the returned 16-bit instruction into the IF/ID pipeline register. Responds to stall, flush and branch-redirect requests from the hazard unit and branch control, and stops fetching after a halt instruction. Sits between instruction_memory and the decode stage in cpu.

Parameters:
ADDR_W, 16, width of the PC and fetch address
INSTR_W, 16, instruction width
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 2, byte increment per instruction
NOP_INSTR, 16'h0000, encoding injected as a bubble
HALT_INSTR, 16'hFFFF, encoding that halts fetch

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
if_from_pc  out  ADDR_W  fetch address to instruction_memory
if_instruction  in  INSTR_W  instruction returned combinationally for if_from_pc in the same cycle
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  hazard unit: replace the IF/ID contents with a bubble
branch_taken  in  1  branch control: redirect the PC
branch_target  in  ADDR_W  redirect address
ifid_instruction  out  INSTR_W  IF/ID instruction
ifid_pc  out  ADDR_W  address of ifid_instruction
ifid_pc_plus2  out  ADDR_W  ifid_pc + PC_STEP
ifid_valid  out  1  IF/ID holds a real instruction
halted  out  1  fetch is halted

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC.
  - ifid_instruction=NOP_INSTR, ifid_pc=0, ifid_pc_plus2=0, ifid_valid=0.
  - halted=0, state=BOOT.
- if_from_pc = PC register output. It is never combinationally derived from the inputs.
- FSM states:
  - BOOT: exactly one cycle after reset deasserts. PC holds, IF/ID holds its bubble, inputs are ignored. Next state is RUN.
  - RUN: the per-edge priority is branch_taken > stall > normal. flush combines with any of these.
  - HALTED: halted=1. PC is frozen and IF/ID is written with a bubble every cycle. stall and flush are ignored.
- RUN, branch_taken=1:
  - PC <= {branch_target[ADDR_W-1:1],1'b0}; bit 0 is always forced to 0.
  - IF/ID <= bubble (NOP_INSTR, valid=0, ifid_pc and ifid_pc_plus2 hold).
  - stall and flush are ignored.
- RUN, stall=1, branch_taken=0:
  - PC holds.
  - IF/ID holds unless flush=1, in which case IF/ID <= bubble.
- RUN, normal:
  - PC <= PC+PC_STEP, modulo 2^ADDR_W, so 16'hFFFE wraps to 16'h0000.
  - If flush=1: IF/ID <= bubble.
  - Otherwise: ifid_instruction<=if_instruction, ifid_pc<=PC, ifid_pc_plus2<=PC+PC_STEP (wrapped), ifid_valid<=1.
- Halt entry:
  - Applies in RUN on a normal, non-flush capture where if_instruction==HALT_INSTR.
  - The halt instruction is captured with valid=1.
  - PC holds instead of incrementing.
  - Next state is HALTED; halted=1 from that edge onward.
  - A halt seen during stall, flush or branch is not acted on.
- HALTED exit: branch_taken=1 loads the aligned target, writes a bubble to IF/ID, sets halted=0 and moves to RUN. Reset also exits HALTED.
- Reset asserted mid-operation overrides everything immediately, including in HALTED and on a branch edge.
- Latency: an instruction at address A appears on ifid_* at the first edge where if_from_pc=A and the capture is normal.

Test Plan:
- Reset then run: hold reset=0 for 3 cycles, release, memory[0,2,4]=1111,2222,3333 -> cycle 1 after release is BOOT (ifid_valid=0, if_from_pc=0); then ifid_instruction = 1111 (pc 0), 2222 (pc 2), 3333 (pc 4) on successive edges, with ifid_pc_plus2 = 2, 4, 6.
- Stall/flush: stall=1 for 2 cycles at PC=6 -> if_from_pc stays 6 and IF/ID unchanged. Then flush=1 with stall=0 -> IF/ID is a bubble (valid=0) and PC=8.
- Branch beats stall: at PC=8 drive branch_taken=1, branch_target=16'h0041, stall=1 -> PC=16'h0040, IF/ID bubble. The next normal edge captures instruction @0x40 with ifid_pc=0x40.
- Wrap: force the branch target to 16'hFFFE -> the next edge gives PC=0 and ifid_pc=FFFE, ifid_pc_plus2=0000.
- Halt: memory[0x10]=FFFF, fetch through it -> ifid_instruction=FFFF with valid=1, then halted=1, PC stays 0x10, IF/ID are bubbles for 5 cycles. branch_taken to 0x20 -> halted=0 and fetch resumes at 0x20.
- Async reset mid-run: pulse reset=0 between clock edges while PC=0x24 -> outputs take their reset values immediately, with no clock edge. After release, BOOT then fetch from 0.
